// File: rtl/wdt_ctrl_pkg.sv
// Shared definitions for the watchdog control front-end: register map,
// interrupt status bit positions and period width.
package wdt_ctrl_pkg;

  localparam int WDT_PERIOD_DWORDS = 2;
  localparam int WDT_PERIOD_W      = 32 * WDT_PERIOD_DWORDS;

  typedef enum logic [3:0] {
    WDT_T1_CTRL      = 4'd0,
    WDT_T1_EN        = 4'd1,
    WDT_T1_PERIOD_LO = 4'd2,
    WDT_T1_PERIOD_HI = 4'd3,
    WDT_T2_CTRL      = 4'd4,
    WDT_T2_EN        = 4'd5,
    WDT_T2_PERIOD_LO = 4'd6,
    WDT_T2_PERIOD_HI = 4'd7,
    WDT_STATUS       = 4'd8,
    WDT_INTR_STS     = 4'd9,
    WDT_INTR_EN      = 4'd10
  } wdt_addr_e;

  localparam int INTR_T1_IDX    = 0;
  localparam int INTR_T2_IDX    = 1;
  localparam int INTR_FATAL_IDX = 2;

endpackage

// File: rtl/wdt_ctrl_if.sv
// Register access bus between the SoC-IFC and the watchdog control block.
interface wdt_ctrl_if;
  logic        req;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/wdt_period_reg.sv
// Timeout period register: LO goes to a shadow, a HI write commits the
// whole period in one edge so the core never sees a half-updated value.
module wdt_period_reg
  import wdt_ctrl_pkg::*;
#(
  parameter logic [WDT_PERIOD_W-1:0] RST_VAL = '1
) (
  input  logic                    clk,
  input  logic                    cptra_rst_b,
  input  logic                    lo_we,
  input  logic                    hi_we,
  input  logic [31:0]             wdata,
  output logic [WDT_PERIOD_W-1:0] period
);

  logic [31:0] shadow_lo;

  always_ff @(posedge clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      shadow_lo <= RST_VAL[31:0];
      period    <= RST_VAL;
    end else begin
      if (lo_we) shadow_lo <= wdata;
      if (hi_we) period    <= {wdata, shadow_lo};
    end
  end

endmodule

// File: rtl/wdt_ctrl.sv
// Firmware-facing watchdog control: register file, period commit, restart
// pulses, sticky interrupt status and timeout-serviced handshake to the core.
module wdt_ctrl
  import wdt_ctrl_pkg::*;
#(
  parameter int WDT_TIMEOUT_PERIOD_NUM_DWORDS = WDT_PERIOD_DWORDS,
  parameter logic [32*WDT_TIMEOUT_PERIOD_NUM_DWORDS-1:0] T1_PERIOD_RST = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter logic [32*WDT_TIMEOUT_PERIOD_NUM_DWORDS-1:0] T2_PERIOD_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                                        clk,
  input  logic                                        cptra_rst_b,
  wdt_ctrl_if.slave                                   bus,
  output logic                                        timer1_en,
  output logic                                        timer2_en,
  output logic                                        timer1_restart,
  output logic                                        timer2_restart,
  output logic [32*WDT_TIMEOUT_PERIOD_NUM_DWORDS-1:0] timer1_timeout_period,
  output logic [32*WDT_TIMEOUT_PERIOD_NUM_DWORDS-1:0] timer2_timeout_period,
  output logic                                        wdt_timer1_timeout_serviced,
  output logic                                        wdt_timer2_timeout_serviced,
  input  logic                                        t1_timeout,
  input  logic                                        t2_timeout,
  input  logic                                        fatal_timeout,
  output logic                                        wdt_intr,
  output logic                                        wdt_fatal
);

  logic        wr_en;
  logic [31:0] rd_mux;
  logic [2:0]  intr_sts, intr_sts_nxt;
  logic [1:0]  intr_en;
  logic [1:0]  svc_nxt;
  logic [1:0]  w1c;
  logic        t1_q, t2_q, fatal_q;
  logic        t1_rise, t2_rise, fatal_rise;

  assign wr_en = bus.req && bus.we;

  wdt_period_reg #(.RST_VAL(T1_PERIOD_RST)) u_t1_period (
    .clk         (clk),
    .cptra_rst_b (cptra_rst_b),
    .lo_we       (wr_en && (bus.addr == WDT_T1_PERIOD_LO)),
    .hi_we       (wr_en && (bus.addr == WDT_T1_PERIOD_HI)),
    .wdata       (bus.wdata),
    .period      (timer1_timeout_period)
  );

  wdt_period_reg #(.RST_VAL(T2_PERIOD_RST)) u_t2_period (
    .clk         (clk),
    .cptra_rst_b (cptra_rst_b),
    .lo_we       (wr_en && (bus.addr == WDT_T2_PERIOD_LO)),
    .hi_we       (wr_en && (bus.addr == WDT_T2_PERIOD_HI)),
    .wdata       (bus.wdata),
    .period      (timer2_timeout_period)
  );

  // Period reads return the committed value, never the LO shadow.
  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      WDT_T1_EN:        rd_mux[0]   = timer1_en;
      WDT_T1_PERIOD_LO: rd_mux      = timer1_timeout_period[31:0];
      WDT_T1_PERIOD_HI: rd_mux      = timer1_timeout_period[63:32];
      WDT_T2_EN:        rd_mux[0]   = timer2_en;
      WDT_T2_PERIOD_LO: rd_mux      = timer2_timeout_period[31:0];
      WDT_T2_PERIOD_HI: rd_mux      = timer2_timeout_period[63:32];
      WDT_STATUS:       rd_mux[2:0] = {fatal_timeout, t2_timeout, t1_timeout};
      WDT_INTR_STS:     rd_mux[2:0] = intr_sts;
      WDT_INTR_EN:      rd_mux[1:0] = intr_en;
      default:          rd_mux      = '0;
    endcase
  end

  assign t1_rise    = t1_timeout    && !t1_q;
  assign t2_rise    = t2_timeout    && !t2_q;
  assign fatal_rise = fatal_timeout && !fatal_q;
  assign w1c        = (wr_en && (bus.addr == WDT_INTR_STS)) ? bus.wdata[1:0] : 2'b00;

  // A new timeout edge beats a same-cycle W1C, and then nothing was serviced.
  always_comb begin
    intr_sts_nxt = intr_sts;
    svc_nxt      = 2'b00;
    if (w1c[0] && intr_sts[INTR_T1_IDX]) begin
      intr_sts_nxt[INTR_T1_IDX] = 1'b0;
      svc_nxt[0]                = 1'b1;
    end
    if (w1c[1] && intr_sts[INTR_T2_IDX]) begin
      intr_sts_nxt[INTR_T2_IDX] = 1'b0;
      svc_nxt[1]                = 1'b1;
    end
    if (t1_rise) begin
      intr_sts_nxt[INTR_T1_IDX] = 1'b1;
      svc_nxt[0]                = 1'b0;
    end
    if (t2_rise) begin
      intr_sts_nxt[INTR_T2_IDX] = 1'b1;
      svc_nxt[1]                = 1'b0;
    end
    if (fatal_rise) intr_sts_nxt[INTR_FATAL_IDX] = 1'b1;
    if (!timer2_en) svc_nxt[1] = 1'b0;
  end

  always_ff @(posedge clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      bus.ack                     <= 1'b0;
      bus.rdata                   <= '0;
      timer1_en                   <= 1'b0;
      timer2_en                   <= 1'b0;
      timer1_restart              <= 1'b0;
      timer2_restart              <= 1'b0;
      intr_en                     <= 2'b00;
      intr_sts                    <= 3'b000;
      t1_q                        <= 1'b0;
      t2_q                        <= 1'b0;
      fatal_q                     <= 1'b0;
      wdt_timer1_timeout_serviced <= 1'b0;
      wdt_timer2_timeout_serviced <= 1'b0;
      wdt_intr                    <= 1'b0;
    end else begin
      bus.ack        <= bus.req;
      bus.rdata      <= (bus.req && !bus.we) ? rd_mux : '0;
      timer1_restart <= wr_en && (bus.addr == WDT_T1_CTRL) && bus.wdata[0];
      timer2_restart <= wr_en && (bus.addr == WDT_T2_CTRL) && bus.wdata[0];
      if (wr_en && (bus.addr == WDT_T1_EN))   timer1_en <= bus.wdata[0];
      if (wr_en && (bus.addr == WDT_T2_EN))   timer2_en <= bus.wdata[0];
      if (wr_en && (bus.addr == WDT_INTR_EN)) intr_en   <= bus.wdata[1:0];
      t1_q                        <= t1_timeout;
      t2_q                        <= t2_timeout;
      fatal_q                     <= fatal_timeout;
      intr_sts                    <= intr_sts_nxt;
      wdt_timer1_timeout_serviced <= svc_nxt[0];
      wdt_timer2_timeout_serviced <= svc_nxt[1];
      wdt_intr                    <= |(intr_sts[INTR_T2_IDX:INTR_T1_IDX] & intr_en);
    end
  end

  assign wdt_fatal = intr_sts[INTR_FATAL_IDX];

endmodule

// File: tb/tb_wdt_ctrl.sv
// Bench for wdt_ctrl: register vector table plus hand-written timing sequences,
// with read data checked through an ack-ordered expectation queue.
module tb_wdt_ctrl;

  logic        clk = 1'b0;
  logic        cptra_rst_b;
  logic        timer1_en, timer2_en, timer1_restart, timer2_restart;
  logic [63:0] t1p, t2p;
  logic        svc1, svc2;
  logic        t1_timeout, t2_timeout, fatal_timeout;
  logic        wdt_intr, wdt_fatal;

  always #5 clk = ~clk;

  wdt_ctrl_if bus();

  wdt_ctrl dut (
    .clk                         (clk),
    .cptra_rst_b                 (cptra_rst_b),
    .bus                         (bus),
    .timer1_en                   (timer1_en),
    .timer2_en                   (timer2_en),
    .timer1_restart              (timer1_restart),
    .timer2_restart              (timer2_restart),
    .timer1_timeout_period       (t1p),
    .timer2_timeout_period       (t2p),
    .wdt_timer1_timeout_serviced (svc1),
    .wdt_timer2_timeout_serviced (svc2),
    .t1_timeout                  (t1_timeout),
    .t2_timeout                  (t2_timeout),
    .fatal_timeout               (fatal_timeout),
    .wdt_intr                    (wdt_intr),
    .wdt_fatal                   (wdt_fatal)
  );

  typedef struct {
    logic [31:0] rdata;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[$];
  int unsigned cyc    = 0;
  int          n_vec  = 0;
  int          n_miss = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every ack retires the oldest outstanding access, exactly one cycle after issue.
  always @(negedge clk) begin
    exp_t e;
    if (bus.ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("ack_spurious", 64'(bus.ack), 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("rdata", 64'(bus.rdata), 64'(e.rdata));
        chk("ack_latency", 64'(cyc), 64'(e.cyc + 1));
      end
    end else begin
      chk("rdata_idle", 64'(bus.rdata), 64'd0);
      if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        e = sb_q.pop_front();
        chk("ack_missing", 64'(bus.ack), 64'd1);
      end
    end
  end

  task automatic bus_op(input logic w, input logic [3:0] a, input logic [31:0] d,
                        input logic [31:0] e, input bit expect_ack = 1'b1);
    exp_t x;
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    if (expect_ack) begin
      x.rdata = e;
      x.cyc   = cyc;
      sb_q.push_back(x);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req = 1'b0;
    bus.we  = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus_op(1'b1, a, d, 32'h0);
    idle();
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    bus_op(1'b0, a, 32'h0, e);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    cptra_rst_b   = 1'b0;
    bus.req       = 1'b0;
    bus.we        = 1'b0;
    bus.addr      = 4'd0;
    bus.wdata     = 32'h0;
    t1_timeout    = 1'b0;
    t2_timeout    = 1'b0;
    fatal_timeout = 1'b0;

    vecs.push_back('{1'b0, 4'd2,  32'h0,         32'hFFFF_FFFF});
    vecs.push_back('{1'b0, 4'd3,  32'h0,         32'hFFFF_FFFF});
    vecs.push_back('{1'b0, 4'd9,  32'h0,         32'h0});
    vecs.push_back('{1'b0, 4'd7,  32'h0,         32'hFFFF_FFFF});
    vecs.push_back('{1'b0, 4'd8,  32'h0,         32'h0});
    vecs.push_back('{1'b0, 4'd1,  32'h0,         32'h0});
    vecs.push_back('{1'b1, 4'd1,  32'h0000_0001, 32'h0});
    vecs.push_back('{1'b0, 4'd1,  32'h0,         32'h1});
    vecs.push_back('{1'b1, 4'd10, 32'hFFFF_FFFD, 32'h0});
    vecs.push_back('{1'b0, 4'd10, 32'h0,         32'h1});
    vecs.push_back('{1'b1, 4'd5,  32'h0000_0001, 32'h0});
    vecs.push_back('{1'b0, 4'd5,  32'h0,         32'h1});
    vecs.push_back('{1'b0, 4'd0,  32'h0,         32'h0});
    vecs.push_back('{1'b1, 4'd12, 32'hDEAD_BEEF, 32'h0});
    vecs.push_back('{1'b0, 4'd12, 32'h0,         32'h0});
    vecs.push_back('{1'b0, 4'd15, 32'h0,         32'h0});

    repeat (2) @(negedge clk);
    chk("rst_ack",    64'(bus.ack),  64'd0);
    chk("rst_intr",   64'(wdt_intr), 64'd0);
    chk("rst_fatal",  64'(wdt_fatal), 64'd0);
    chk("rst_t1_en",  64'(timer1_en), 64'd0);
    chk("rst_t1p",    t1p, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_t2p",    t2p, 64'hFFFF_FFFF_FFFF_FFFF);
    cptra_rst_b = 1'b1;

    // Register table, issued back-to-back.
    foreach (vecs[i]) bus_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);
    idle();

    // Period commit on HI only; reads show the committed value.
    wr(4'd2, 32'h10);
    chk("t1p_lo_only", t1p, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(4'd2, 32'hFFFF_FFFF);
    wr(4'd3, 32'h0);
    chk("t1p_hi_commit", t1p, 64'h10);
    rd(4'd2, 32'h10);
    rd(4'd3, 32'h0);
    wr(4'd7, 32'h5);
    chk("t2p_hi_no_lo", t2p, 64'h0000_0005_FFFF_FFFF);

    // Restart pulses.
    wr(4'd0, 32'h1);
    chk("t1_restart_hi", 64'(timer1_restart), 64'd1);
    chk("t2_restart_idle", 64'(timer2_restart), 64'd0);
    @(negedge clk);
    chk("t1_restart_lo", 64'(timer1_restart), 64'd0);
    wr(4'd4, 32'hFFFF_FFFE);
    chk("t2_restart_bit0_clr", 64'(timer2_restart), 64'd0);
    wr(4'd4, 32'h1);
    chk("t2_restart_hi", 64'(timer2_restart), 64'd1);

    // t1 timeout -> status, interrupt, W1C service.
    @(negedge clk);
    t1_timeout = 1'b1;
    rd(4'd9, 32'h1);
    chk("intr_set", 64'(wdt_intr), 64'd1);
    wr(4'd9, 32'h1);
    chk("svc1_pulse", 64'(svc1), 64'd1);
    chk("svc2_quiet", 64'(svc2), 64'd0);
    @(negedge clk);
    chk("svc1_one_cycle", 64'(svc1), 64'd0);
    chk("intr_drop", 64'(wdt_intr), 64'd0);
    rd(4'd9, 32'h0);

    // New t1 edge coincident with W1C: set wins, no service pulse.
    @(negedge clk);
    t1_timeout = 1'b0;
    @(negedge clk);
    t1_timeout = 1'b1;
    @(negedge clk);
    t1_timeout = 1'b0;
    bus_op(1'b1, 4'd9, 32'h1, 32'h0);
    t1_timeout = 1'b1;
    idle();
    chk("svc1_set_wins", 64'(svc1), 64'd0);
    rd(4'd9, 32'h1);
    wr(4'd9, 32'h1);
    chk("svc1_after_set_wins", 64'(svc1), 64'd1);

    // Cascade mode suppresses the timer2 service pulse.
    wr(4'd5, 32'h0);
    @(negedge clk);
    t2_timeout = 1'b1;
    rd(4'd9, 32'h2);
    wr(4'd9, 32'h2);
    chk("svc2_cascade", 64'(svc2), 64'd0);
    rd(4'd9, 32'h0);
    wr(4'd5, 32'h1);
    @(negedge clk);
    t2_timeout = 1'b0;
    @(negedge clk);
    t2_timeout = 1'b1;
    rd(4'd9, 32'h2);
    wr(4'd9, 32'h2);
    chk("svc2_pulse", 64'(svc2), 64'd1);
    @(negedge clk);
    chk("svc2_one_cycle", 64'(svc2), 64'd0);

    // Fatal is sticky through W1C, cleared only by reset.
    @(negedge clk);
    fatal_timeout = 1'b1;
    @(negedge clk);
    chk("fatal_set", 64'(wdt_fatal), 64'd1);
    rd(4'd9, 32'h4);
    wr(4'd9, 32'h7);
    rd(4'd9, 32'h4);
    chk("fatal_w1c_ignored", 64'(wdt_fatal), 64'd1);
    rd(4'd8, 32'h7);

    // Reset during an access: the access is dropped.
    bus_op(1'b0, 4'd9, 32'h0, 32'h0, 1'b0);
    #2;
    cptra_rst_b   = 1'b0;
    t1_timeout    = 1'b0;
    t2_timeout    = 1'b0;
    fatal_timeout = 1'b0;
    #1;
    chk("fatal_rst", 64'(wdt_fatal), 64'd0);
    chk("t1p_rst", t1p, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t1_en_rst", 64'(timer1_en), 64'd0);
    idle();
    @(negedge clk);
    cptra_rst_b = 1'b1;
    rd(4'd2, 32'hFFFF_FFFF);
    rd(4'd9, 32'h0);
    chk("fatal_after_rst", 64'(wdt_fatal), 64'd0);
    chk("intr_after_rst", 64'(wdt_intr), 64'd0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/wdt_ctrl.md
Name: wdt_ctrl

Overview:
- Firmware-facing control and service front-end for the two-timer watchdog.
- Drives timer enables, restart pulses and 64-bit timeout periods into the watchdog core.
- Receives the core's t1/t2/fatal timeout status and converts it into sticky interrupt status, an interrupt line and a fatal error line.
- Turns firmware W1C acknowledgements into single-cycle timeout-serviced pulses back to the core; sits between the SoC-IFC register bus and the watchdog core.

Parameters:
- WDT_TIMEOUT_PERIOD_NUM_DWORDS, 2, period width in dwords; fixed at 2 by the address map.
- T1_PERIOD_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of the timer1 period.
- T2_PERIOD_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of the timer2 period.

Ports:
- clk  in  1  clock.
- cptra_rst_b  in  1  asynchronous active-low reset.
- req  in  1  register access request, one-cycle qualifier.
- we  in  1  1 = write, 0 = read.
- addr  in  4  dword register address.
- wdata  in  32  write data.
- ack  out  1  access complete, the cycle after req.
- rdata  out  32  read data, valid with ack.
- timer1_en  out  1  to watchdog core.
- timer2_en  out  1  to watchdog core; 0 = cascade mode.
- timer1_restart  out  1  one-cycle pulse.
- timer2_restart  out  1  one-cycle pulse.
- timer1_timeout_period  out  64  committed period.
- timer2_timeout_period  out  64  committed period.
- wdt_timer1_timeout_serviced  out  1  one-cycle pulse.
- wdt_timer2_timeout_serviced  out  1  one-cycle pulse.
- t1_timeout  in  1  live status from core.
- t2_timeout  in  1  live status from core.
- fatal_timeout  in  1  live status from core.
- wdt_intr  out  1  level interrupt to core.
- wdt_fatal  out  1  level fatal error to SoC.

Behaviour:
- Register map (addr):
  - 0 T1_CTRL: bit0 restart, W1 pulse, reads 0.
  - 1 T1_EN: bit0.
  - 2 T1_PERIOD_LO.
  - 3 T1_PERIOD_HI.
  - 4 T2_CTRL.
  - 5 T2_EN.
  - 6 T2_PERIOD_LO.
  - 7 T2_PERIOD_HI.
  - 8 STATUS: RO {fatal, t2, t1} live.
  - 9 INTR_STS: bit0 t1, bit1 t2, bit2 fatal; W1C on bits 0-1.
  - 10 INTR_EN: bits 0-1.
  - 11-15: reads 0, writes ignored, ack still returned.
- Handshake:
  - ack asserts exactly one cycle after req.
  - rdata is registered and valid only with ack; rdata is 0 when ack is 0.
  - Back-to-back req every cycle is legal.
- Period commit:
  - A LO write stores to a shadow register.
  - A HI write commits {wdata, shadow} to the period output in the same clock edge.
  - A HI write without a prior LO write commits the current shadow (reset 0 for the shadow? no: shadow resets to the low dword of *_PERIOD_RST).
  - Reads of LO/HI return the committed period, not the shadow.
- Restart:
  - A write with bit0=1 to T*_CTRL produces a one-cycle restart pulse on the cycle after the write (registered).
  - The T2 restart is still emitted in cascade mode; the core ignores it.
- Interrupt status:
  - INTR_STS bit0 sets on the rising edge of t1_timeout; bit1 sets on the rising edge of t2_timeout.
  - Edges are detected against a registered copy of the input; the registered copies reset to 0.
  - If set and W1C land in the same cycle, set wins.
- Serviced pulses:
  - A W1C of bit0 while bit0=1 clears it and emits wdt_timer1_timeout_serviced for exactly one cycle, on the cycle after the write.
  - The same rule applies to bit1 and timer2.
  - W1C of an already-clear bit emits no pulse.
  - The timer2 serviced pulse is suppressed when timer2_en=0 (cascade mode).
- Interrupt and fatal lines:
  - wdt_intr = |(INTR_STS[1:0] & INTR_EN[1:0]), registered.
  - INTR_STS bit2 sets on the rising edge of fatal_timeout and is sticky until reset; W1C is ignored.
  - wdt_fatal = bit2.
- Reset values:
  - ack, rdata, enables, pulses, INTR_STS, INTR_EN, wdt_intr, wdt_fatal all reset to 0.
  - Periods reset to *_PERIOD_RST.
  - Reset mid-access drops the access with no ack.

Decomposition:
- Shared package wdt_ctrl_pkg holds:
  - the address enum (WDT_T1_CTRL .. WDT_INTR_EN);
  - INTR_STS bit index constants;
  - the period width localparam.
- One sub-module, wdt_period_reg: shadow LO, HI commit and reset value, instantiated once per timer.

Test Plan:
- Reset, then read addr 2/3 -> 0xFFFF_FFFF each; read addr 9 -> 0; wdt_intr=0, wdt_fatal=0.
- Write LO=0x10, HI=0x0 to T1 -> timer1_timeout_period changes from all-ones to 64'h10 only on the HI edge; a LO-only write leaves the output unchanged.
- Set INTR_EN=1, pulse t1_timeout high -> INTR_STS=1 and wdt_intr=1 one cycle later; W1C 0x1 -> one-cycle wdt_timer1_timeout_serviced, INTR_STS=0, wdt_intr drops.
- t1_timeout rising edge coincident with a W1C of bit0 -> bit0 stays 1, no serviced pulse.
- timer2_en=0, t2 rising edge, W1C 0x2 -> bit1 clears, no wdt_timer2_timeout_serviced pulse; with timer2_en=1 the pulse appears.
- fatal_timeout rising edge -> wdt_fatal=1; W1C 0x4 -> still 1; cptra_rst_b low -> 0.
